// File: rtl/z80_bus_master_if.sv
// Z80 bus master interface bundle.
// Groups the internal request/response handshake, the T-state enable and
// the external Z80 bus (address, data, strobes, WAIT) into one port.
//   master modport: the bus master block (drives strobes, A, dout, status).
//   slave modport : the requester / bus model side (drives req_*, tce,
//                   wait_n, di, i_reg).
interface z80_bus_master_if;
    // request side
    logic        tce;
    logic        req;
    logic [1:0]  req_kind;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  i_reg;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  rdata;
    // external bus side
    logic [15:0] A;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        wait_n;
    logic [7:0]  di;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;

    modport master (
        input  tce, req, req_kind, req_we, req_addr, req_wdata, i_reg, wait_n, di,
        output busy, done, timeout, rdata, A, dout, dout_oe,
               m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
    );

    modport slave (
        output tce, req, req_kind, req_we, req_addr, req_wdata, i_reg, wait_n, di,
        input  busy, done, timeout, rdata, A, dout, dout_oe,
               m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
    );
endinterface

// File: rtl/z80_bus_master.sv
// Z80-style external bus initiator.
// Turns single-word requests into Z80-timed machine cycles: opcode fetch
// (M1 + refresh), memory read/write and I/O read/write, honouring WAIT.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      z80_bus_master_if.master: tce, req/req_kind/req_we/req_addr/
//            req_wdata, i_reg, busy/done/timeout/rdata, A, dout, dout_oe,
//            wait_n, di, m1_n/mreq_n/iorq_n/rd_n/wr_n/rfsh_n
// Parameters:
//   WAIT_MAX      wait states tolerated before the cycle is aborted
//   IO_AUTO_WAIT  forced wait states in I/O cycles (0 or 1)
module z80_bus_master #(
    parameter int WAIT_MAX     = 255,
    parameter int IO_AUTO_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    z80_bus_master_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    state_t      state, state_nx;
    logic [1:0]  kind_r;
    logic        we_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic [7:0]  tw_cnt;
    logic [7:0]  rdata_r;
    logic [6:0]  r_cnt;
    logic        done_r, timeout_r;
    logic        accept, finish, abort, tw_inc, latch_rd;
    logic        is_fetch, is_io, data_ph;

    assign is_fetch = (kind_r == 2'b10);
    assign is_io    = (kind_r == 2'b01);   // 00 and reserved 11 are memory
    assign data_ph  = (state == S_T2) || (state == S_TW);

    // Next-state logic. Only IDLE accept runs without tce.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        tw_inc   = 1'b0;
        latch_rd = 1'b0;
        case (state)
            S_IDLE: if (bus.req) begin
                accept   = 1'b1;
                state_nx = S_T1;
            end
            S_T1: if (bus.tce) state_nx = S_T2;
            S_T2, S_TW: if (bus.tce) begin
                // I/O: the forced TW is entered unconditionally; its end is
                // the first WAIT sample, so no separate flag is needed.
                if (state == S_T2 && is_io && IO_AUTO_WAIT != 0) begin
                    state_nx = S_TW;
                end else if (!bus.wait_n) begin
                    if (tw_cnt == 8'(WAIT_MAX)) begin
                        abort    = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        tw_inc   = 1'b1;
                        state_nx = S_TW;
                    end
                end else begin
                    state_nx = S_T3;
                    latch_rd = is_fetch;   // fetch data is taken before refresh
                end
            end
            S_T3: if (bus.tce) begin
                if (is_fetch) begin
                    state_nx = S_T4;
                end else begin
                    finish   = 1'b1;
                    latch_rd = !we_r;
                    state_nx = S_IDLE;
                end
            end
            S_T4: if (bus.tce) begin
                finish   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the current T-state and the latched request.
    always_comb begin
        bus.m1_n    = 1'b1;
        bus.mreq_n  = 1'b1;
        bus.iorq_n  = 1'b1;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.rfsh_n  = 1'b1;
        bus.dout_oe = 1'b0;
        bus.A       = addr_r;
        if (state != S_IDLE) begin
            if (is_fetch) begin
                if (state == S_T1 || data_ph) begin
                    bus.m1_n   = 1'b0;
                    bus.mreq_n = 1'b0;
                    bus.rd_n   = 1'b0;
                end else begin
                    bus.rfsh_n = 1'b0;
                    bus.mreq_n = (state != S_T3);
                    bus.A      = {bus.i_reg, 1'b0, r_cnt};
                end
            end else if (is_io) begin
                if (state != S_T1) begin
                    bus.iorq_n = 1'b0;
                    bus.rd_n   = we_r;
                    bus.wr_n   = !we_r;
                end
                bus.dout_oe = we_r;
            end else begin
                bus.mreq_n  = 1'b0;
                bus.rd_n    = we_r;
                bus.wr_n    = !(we_r && state != S_T1);
                bus.dout_oe = we_r;
            end
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_r;
    assign bus.timeout = timeout_r;
    assign bus.rdata   = rdata_r;
    assign bus.dout    = wdata_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            kind_r    <= 2'b00;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            tw_cnt    <= '0;
            rdata_r   <= '0;
            r_cnt     <= '0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= finish | abort;
            if (accept) begin
                kind_r  <= bus.req_kind;
                we_r    <= bus.req_we && (bus.req_kind != 2'b10);
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                tw_cnt  <= '0;
            end
            if (tw_inc)           tw_cnt    <= tw_cnt + 8'd1;
            if (latch_rd)         rdata_r   <= bus.di;
            if (finish | abort)   timeout_r <= abort;
            // an aborted fetch never reaches T4, so R only moves on success
            if (finish && is_fetch) r_cnt   <= r_cnt + 7'd1;
        end
    end
endmodule

// File: tb/tb_z80_bus_master.sv
module tb_z80_bus_master;
    localparam int WAIT_MAX     = 4;
    localparam int IO_AUTO_WAIT = 1;
    localparam logic [7:0] IREG = 8'h3F;
    localparam int P_T1 = 0, P_T2 = 1, P_TWF = 2, P_TW = 3, P_T3 = 4, P_T4 = 5;

    typedef struct { int ph; logic w; } ts_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    z80_bus_master_if bus();

    z80_bus_master #(.WAIT_MAX(WAIT_MAX), .IO_AUTO_WAIT(IO_AUTO_WAIT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expectations for the current cycle (set by the driver)
    logic [5:0]  exp_strb = 6'h3F;      // {m1,mreq,iorq,rd,wr,rfsh}
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_oe = 1'b0, exp_tmo = 1'b0;
    logic [7:0]  exp_dout = 8'h00, exp_rdata = 8'h00;
    logic [15:0] exp_A = 16'h0000;
    bit          chk_en = 1'b0, chk_A = 1'b0, chk_tmo = 1'b0;
    int          txn = 0;

    // literal pin checks, handed to the compare process
    string       lit_name = "";
    logic [31:0] lit_act = 0, lit_exp = 0;
    int          lit_id = 0;
    int          lit_seen = 0;

    // per-transaction observations
    int          seen_txn = -1;
    int          cyc = 0, done_at = -1;
    int          n_mreq = 0, n_rd = 0, n_wr = 0, n_iorq = 0, n_rfsh = 0, n_m1 = 0, n_oe = 0;
    logic [15:0] rfsh_a = 16'h0000;

    // model state
    logic [6:0]  m_r = 7'd0;
    logic [7:0]  m_rdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // single compare process
    always @(negedge clk) begin
        if (txn != seen_txn) begin
            seen_txn = txn; cyc = 0; done_at = -1;
            n_mreq = 0; n_rd = 0; n_wr = 0; n_iorq = 0; n_rfsh = 0; n_m1 = 0; n_oe = 0;
        end else begin
            cyc++;
        end
        if (!bus.mreq_n) n_mreq++;
        if (!bus.rd_n)   n_rd++;
        if (!bus.wr_n)   n_wr++;
        if (!bus.iorq_n) n_iorq++;
        if (!bus.m1_n)   n_m1++;
        if (bus.dout_oe) n_oe++;
        if (!bus.rfsh_n) begin
            if (n_rfsh == 0) rfsh_a = bus.A;
            n_rfsh++;
        end
        if (bus.done && done_at < 0) done_at = cyc;
        if (chk_en) begin
            chk("strobes", 32'({bus.m1_n, bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.rfsh_n}),
                32'(exp_strb));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("dout_oe", 32'(bus.dout_oe), 32'(exp_oe));
            if (exp_oe) chk("dout", 32'(bus.dout), 32'(exp_dout));
            if (chk_A) chk("A", 32'(bus.A), 32'(exp_A));
            if (!exp_busy) chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
            if (chk_tmo) chk("timeout", 32'(bus.timeout), 32'(exp_tmo));
        end
        if (lit_id != lit_seen) begin
            lit_seen = lit_id;
            chk(lit_name, lit_act, lit_exp);
        end
    end

    // expected strobes for one T-state of a cycle, straight from the timing table
    function automatic logic [5:0] phase_strb(input int ph, input logic [1:0] kind, input logic we);
        logic m1, mreq, iorq, rd, wr, rf;
        bit dph;
        m1 = 1; mreq = 1; iorq = 1; rd = 1; wr = 1; rf = 1;
        dph = (ph == P_T2 || ph == P_TWF || ph == P_TW);
        if (kind == 2'b10) begin
            if (ph == P_T1 || dph) begin m1 = 0; mreq = 0; rd = 0; end
            if (ph == P_T3) begin mreq = 0; rf = 0; end
            if (ph == P_T4) rf = 0;
        end else if (kind == 2'b01) begin
            if (ph != P_T1) begin iorq = 0; if (we) wr = 0; else rd = 0; end
        end else begin
            mreq = 0;
            if (we) begin if (ph != P_T1) wr = 0; end
            else rd = 0;
        end
        return {m1, mreq, iorq, rd, wr, rf};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_idle(input logic d);
        exp_strb = 6'h3F; exp_busy = 1'b0; exp_done = d; exp_oe = 1'b0;
        chk_A = 1'b0; exp_rdata = m_rdata;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name = name; lit_act = act; lit_exp = exp; lit_id++;
        @(negedge clk); #1;
    endtask

    // One machine cycle. nwait = number of WAIT-low samples; gaps = tce=0
    // clocks inserted before every tce=1 clock.
    task automatic run(input logic [1:0] kind, input logic we, input logic [15:0] addr,
                       input logic [7:0] wdata, input logic [7:0] data,
                       input int nwait, input int gaps);
        ts_t seq[$];
        ts_t e;
        int  n_tw, li, k;
        bit  ab, fetch, mw;
        fetch = (kind == 2'b10);
        mw    = we && !fetch;
        e.w = 1'b0;
        e.ph = P_T1; seq.push_back(e);
        e.ph = P_T2; seq.push_back(e);
        if (kind == 2'b01 && IO_AUTO_WAIT != 0) begin e.ph = P_TWF; seq.push_back(e); end
        n_tw = 0; ab = 0; li = -1;
        for (int s = 0; s < 1000; s++) begin
            if (s >= nwait) begin
                k = seq.size() - 1; e = seq[k]; e.w = 1'b1; seq[k] = e;
                if (fetch) li = k;
                break;
            end
            if (n_tw == WAIT_MAX) begin ab = 1; break; end
            e.ph = P_TW; e.w = 1'b0; seq.push_back(e); n_tw++;
        end
        if (!ab) begin
            e.ph = P_T3; e.w = 1'b0; seq.push_back(e);
            if (!fetch && !mw) li = seq.size() - 1;
            if (fetch) begin e.ph = P_T4; seq.push_back(e); end
        end

        // request cycle: accepted whatever tce is
        txn++;
        bus.req = 1'b1; bus.req_kind = kind; bus.req_we = we;
        bus.req_addr = addr; bus.req_wdata = wdata;
        bus.tce = (gaps == 0); bus.wait_n = 1'b1; bus.di = ~data;
        set_idle(1'b0);
        step();
        // scramble request inputs: the cycle must run on latched values
        bus.req_addr = ~addr; bus.req_wdata = ~wdata; bus.req_we = !we; bus.req_kind = ~kind;
        foreach (seq[i]) begin
            for (int g = 0; g <= gaps; g++) begin
                bus.tce    = (g == gaps);
                bus.req    = (i == 1);              // must be ignored while busy
                bus.wait_n = (g == gaps) ? seq[i].w : 1'b0;
                bus.di     = ((g == gaps) && i == li) ? data : ~data;
                exp_strb = phase_strb(seq[i].ph, kind, mw);
                exp_busy = 1'b1; exp_done = 1'b0; exp_oe = mw; exp_dout = wdata;
                chk_A = 1'b1;
                exp_A = (fetch && (seq[i].ph == P_T3 || seq[i].ph == P_T4)) ? {IREG, 1'b0, m_r} : addr;
                step();
            end
        end
        if (li >= 0) m_rdata = data;
        bus.req = 1'b0; bus.tce = (gaps == 0); bus.wait_n = 1'b1;
        set_idle(1'b1); chk_tmo = 1'b1; exp_tmo = ab;
        step();
        chk_tmo = 1'b0;
        if (fetch && !ab) m_r = m_r + 7'd1;
        set_idle(1'b0);
    endtask

    initial begin
        bus.req = 1'b0; bus.req_kind = 2'b00; bus.req_we = 1'b0; bus.req_addr = 16'h0;
        bus.req_wdata = 8'h0; bus.i_reg = IREG; bus.tce = 1'b1; bus.wait_n = 1'b1; bus.di = 8'h0;
        set_idle(1'b0); chk_A = 1'b1; exp_A = 16'h0; chk_tmo = 1'b1; exp_tmo = 1'b0;
        chk_en = 1'b1;
        step(); step();
        reset_n = 1'b1;
        step();
        chk_A = 1'b0; chk_tmo = 1'b0;

        // mem read, no wait
        run(2'b00, 1'b0, 16'h4000, 8'h00, 8'hA5, 0, 0);
        lit("mr_rd_clks", 32'(n_rd), 32'd3);
        lit("mr_mreq_clks", 32'(n_mreq), 32'd3);
        lit("mr_done_at", 32'(done_at), 32'd4);
        lit("mr_rdata", 32'(bus.rdata), 32'hA5);
        step();

        // mem write, two wait samples
        run(2'b00, 1'b1, 16'h5800, 8'h3C, 8'h00, 2, 0);
        lit("mw_wr_clks", 32'(n_wr), 32'd4);
        lit("mw_oe_clks", 32'(n_oe), 32'd5);
        lit("mw_mreq_clks", 32'(n_mreq), 32'd5);
        step();

        // I/O read with the automatic wait state
        run(2'b01, 1'b0, 16'h00FE, 8'h00, 8'h5A, 0, 0);
        lit("io_iorq_clks", 32'(n_iorq), 32'd3);
        lit("io_mreq_clks", 32'(n_mreq), 32'd0);
        lit("io_done_at", 32'(done_at), 32'd5);
        lit("io_rdata", 32'(bus.rdata), 32'h5A);
        step();

        // I/O write, one wait, tce gaps
        run(2'b01, 1'b1, 16'h00FF, 8'hC3, 8'h00, 1, 1);
        // exactly WAIT_MAX waits still completes
        run(2'b00, 1'b0, 16'h1234, 8'h00, 8'h69, WAIT_MAX, 2);
        lit("wmax_rd_clks", 32'(n_rd), 32'd21);
        step();
        // WAIT held low: timeout, rdata unchanged
        run(2'b00, 1'b0, 16'h2222, 8'h00, 8'hEE, 100, 0);
        lit("tmo_done_at", 32'(done_at), 32'd7);
        lit("tmo_rdata", 32'(bus.rdata), 32'h69);
        step();
        // reserved kind behaves as memory
        run(2'b11, 1'b0, 16'hABCD, 8'h00, 8'h17, 1, 0);
        // fetch timeout: R must not advance
        run(2'b10, 1'b1, 16'h0100, 8'h00, 8'hED, 100, 1);

        // walk R up to 0x7F with checked fetches
        for (int n = 0; n < 200 && m_r != 7'h7F; n++)
            run(2'b10, 1'b0, {9'h0, m_r}, 8'h00, {1'b1, m_r}, int'(m_r[0]), 0);

        run(2'b10, 1'b0, 16'h0000, 8'h00, 8'hCB, 0, 0);
        lit("f1_rfsh_a", 32'(rfsh_a), 32'h3F7F);
        lit("f1_rfsh_clks", 32'(n_rfsh), 32'd2);
        lit("f1_m1_clks", 32'(n_m1), 32'd2);
        lit("f1_done_at", 32'(done_at), 32'd5);
        lit("f1_rdata", 32'(bus.rdata), 32'hCB);
        step();
        run(2'b10, 1'b0, 16'h0001, 8'h00, 8'h44, 0, 0);
        lit("f2_rfsh_a", 32'(rfsh_a), 32'h3F00);
        step();

        // reset in the middle of a write's wait states, tce toggling
        txn++;
        bus.req = 1'b1; bus.req_kind = 2'b00; bus.req_we = 1'b1;
        bus.req_addr = 16'h6000; bus.req_wdata = 8'h55; bus.tce = 1'b1; bus.wait_n = 1'b1;
        set_idle(1'b0);
        step();
        bus.req = 1'b0; chk_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.tce = k[0]; bus.wait_n = 1'b0;
            step();
        end
        bus.tce = 1'b0;
        lit("rst_pre_wr_n", 32'(bus.wr_n), 32'd0);
        lit("rst_pre_busy", 32'(bus.busy), 32'd1);
        step();
        reset_n = 1'b0; bus.tce = 1'b1;
        step();
        reset_n = 1'b0; bus.tce = 1'b0;
        m_r = 7'd0; m_rdata = 8'h00;
        set_idle(1'b0); chk_A = 1'b1; exp_A = 16'h0; chk_tmo = 1'b1; exp_tmo = 1'b0;
        chk_en = 1'b1;
        step();
        reset_n = 1'b1; bus.wait_n = 1'b1;
        step();
        chk_A = 1'b0; chk_tmo = 1'b0;

        run(2'b10, 1'b0, 16'h0000, 8'h00, 8'h99, 0, 0);
        lit("post_rst_rfsh_a", 32'(rfsh_a), 32'h3F00);
        step();
        run(2'b00, 1'b1, 16'h7000, 8'hA1, 8'h00, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
